// File: rtl/rca_serial_adder.sv
// Multi-cycle ripple-carry adder: adds two WIDTH-bit operands plus a
// carry-in, CHUNK bits per clock, LSB chunk first, with the carry held in a
// register between chunks. Results are published only when the last chunk
// completes, so sum/cout/overflow never show partial values.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Input side accepts only in IDLE (in_ready), output side
// presents only in DONE (out_valid) and holds until out_ready is seen.
// Inputs are ignored whenever in_ready is low; out_ready is ignored
// outside DONE.
module rca_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("rca_serial_adder: CHUNK must divide WIDTH and both must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state;
  state_t state_next;

  // Latched operands are shifted right each BUSY edge so the current chunk
  // always sits in the low CHUNK bits; the MSBs are kept for overflow.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] a_sh_next;
  logic [WIDTH-1:0] b_sh_next;
  logic             a_msb;
  logic             b_msb;
  logic             carry;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [CHUNK:0]   chunk_res;
  logic             last_chunk;

  assign last_chunk = (k == LAST);

  // One CHUNK-bit add of the current chunk plus the registered carry.
  assign chunk_res = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};

  // The working sum fills from the top: each new chunk enters at the MSB end
  // and earlier chunks move down, so after NCHUNK edges chunk 0 is at bit 0.
  generate
    if (NCHUNK == 1) begin : g_single
      assign work_next = chunk_res[CHUNK-1:0];
      assign a_sh_next = '0;
      assign b_sh_next = '0;
    end else begin : g_multi
      assign work_next = {chunk_res[CHUNK-1:0], work[WIDTH-1:CHUNK]};
      assign a_sh_next = {{CHUNK{1'b0}}, a_sh[WIDTH-1:CHUNK]};
      assign b_sh_next = {{CHUNK{1'b0}}, b_sh[WIDTH-1:CHUNK]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = BUSY;
      BUSY:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    dbg_state = state;
  end

  // Datapath: latch on accept, add one chunk per BUSY edge, publish on the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      carry    <= 1'b0;
      k        <= '0;
      work     <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            carry <= cin;
            k     <= '0;
            work  <= '0;
          end
        end
        BUSY: begin
          a_sh  <= a_sh_next;
          b_sh  <= b_sh_next;
          work  <= work_next;
          carry <= chunk_res[CHUNK];
          k     <= k + CW'(1);
          if (last_chunk) begin
            sum      <= work_next;
            cout     <= chunk_res[CHUNK];
            overflow <= (a_msb == b_msb) && (work_next[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_serial_adder.sv
// Bench for rca_serial_adder: three instances (8/4, 4/1, 8/8) share clock
// and reset. Drivers push the model result into a per-instance queue when
// operands are presented; monitors pop and compare on each output handshake.
module tb_rca_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;

  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] st4;

  logic       in_validw, in_readyw, cinw, out_validw, out_readyw, coutw, ovfw;
  logic [7:0] aw, bw, sumw;
  logic [1:0] stw;

  rca_serial_adder #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .overflow(ovf8), .dbg_state(st8)
  );

  rca_serial_adder #(.WIDTH(4), .CHUNK(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .overflow(ovf4), .dbg_state(st4)
  );

  rca_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dutw (
    .clk(clk), .rst(rst), .in_valid(in_validw), .in_ready(in_readyw),
    .a(aw), .b(bw), .cin(cinw), .out_valid(out_validw), .out_ready(out_readyw),
    .sum(sumw), .cout(coutw), .overflow(ovfw), .dbg_state(stw)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Result packing: [9]=cout, [8:1]=sum (zero-extended), [0]=overflow.
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q2[$];

  function automatic logic [9:0] model(input int w, input logic [7:0] a,
                                       input logic [7:0] b, input logic c);
    logic [8:0] t;
    logic [9:0] r;
    if (w == 1) begin
      t = 9'(a[3:0]) + 9'(b[3:0]) + 9'(c);
      r = {t[4], 4'h0, t[3:0], (a[3] == b[3]) && (t[3] != a[3])};
    end else begin
      t = 9'(a) + 9'(b) + 9'(c);
      r = {t[8], t[7:0], (a[7] == b[7]) && (t[7] != a[7])};
    end
    return r;
  endfunction

  // ---------------- scoreboard monitors ----------------
  logic [9:0] e0, e1, e2;

  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (exp_q0.size() == 0) check("sb8_unexpected_output", 1, 0);
      else begin
        e0 = exp_q0.pop_front();
        check("sum8", sum8, e0[8:1]);
        check("cout8", cout8, e0[9]);
        check("ovf8", ovf8, e0[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (exp_q1.size() == 0) check("sb4_unexpected_output", 1, 0);
      else begin
        e1 = exp_q1.pop_front();
        check("sum4", sum4, e1[4:1]);
        check("cout4", cout4, e1[9]);
        check("ovf4", ovf4, e1[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_validw && out_readyw) begin
      if (exp_q2.size() == 0) check("sbw_unexpected_output", 1, 0);
      else begin
        e2 = exp_q2.pop_front();
        check("sumw", sumw, e2[8:1]);
        check("coutw", coutw, e2[9]);
        check("ovfw", ovfw, e2[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic rdy(input int w);
    case (w)
      0:       return in_ready8;
      1:       return in_ready4;
      default: return in_readyw;
    endcase
  endfunction

  function automatic logic ov(input int w);
    case (w)
      0:       return out_valid8;
      1:       return out_valid4;
      default: return out_validw;
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    case (w)
      0:       begin in_valid8 = v; a8 = a; b8 = b; cin8 = c; end
      1:       begin in_valid4 = v; a4 = a[3:0]; b4 = b[3:0]; cin4 = c; end
      default: begin in_validw = v; aw = a; bw = b; cinw = c; end
    endcase
  endtask

  task automatic push(input int w, input logic [9:0] r);
    case (w)
      0:       exp_q0.push_back(r);
      1:       exp_q1.push_back(r);
      default: exp_q2.push_back(r);
    endcase
  endtask

  // Waits for out_valid after an accept edge; returns edges counted.
  task automatic wait_result(input int w, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ov(w) && lat < 40);
  endtask

  // One full transaction with out_ready held high.
  task automatic send(input int w, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input int lat_exp);
    int guard;
    int lat;
    guard = 0;
    @(negedge clk);
    while (!rdy(w) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", guard < 50, 1);
    drive(w, 1'b1, a, b, c);
    push(w, model(w, a, b, c));
    @(posedge clk);
    #1 drive(w, 1'b0, a, b, c);
    wait_result(w, lat);
    check("latency", lat, lat_exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst = 1'b1;
    out_ready8 = 1'b1; out_ready4 = 1'b1; out_readyw = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset for two cycles, check reset outputs.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready8, 1);
    check("rst_out_valid", out_valid8, 0);
    check("rst_sum", sum8, 8'h00);
    check("rst_cout", cout8, 0);
    check("rst_ovf", ovf8, 0);
    check("rst_state", st8, 2'd0);
    check("rst_in_ready4", in_ready4, 1);
    check("rst_in_readyw", in_readyw, 1);

    // Carry across the chunk boundary, carry-out and overflow corners.
    send(0, 8'h0F, 8'h01, 1'b0, 2);
    send(0, 8'hFF, 8'h00, 1'b1, 2);
    send(0, 8'h7F, 8'h01, 1'b0, 2);
    send(0, 8'h80, 8'h80, 1'b0, 2);

    // Backpressure: result held while new operands wait with in_valid high.
    out_ready8 = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 8'hC3, 8'h4E, 1'b1);
    push(0, model(0, 8'hC3, 8'h4E, 1'b1));
    @(posedge clk);
    #1 drive(0, 1'b1, 8'h3C, 8'h4D, 1'b0);
    push(0, model(0, 8'h3C, 8'h4D, 1'b0));
    wait_result(0, lat);
    check("bp_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", out_valid8, 1);
      check("bp_in_ready", in_ready8, 0);
      check("bp_sum_hold", sum8, 8'h12);
      check("bp_cout_hold", cout8, 1);
    end
    @(posedge clk);
    #1 out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_ready", in_ready8, 1);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h3C, 8'h4D, 1'b0);
    wait_result(0, lat);
    check("bp_next_latency", lat, 2);
    @(posedge clk);
    #1;

    // Reset one edge into BUSY discards the in-flight op.
    @(negedge clk);
    drive(0, 1'b1, 8'h55, 8'h22, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h55, 8'h22, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready8, 1);
    check("abort_out_valid", out_valid8, 0);
    check("abort_sum", sum8, 8'h00);
    check("abort_cout", cout8, 0);
    check("abort_ovf", ovf8, 0);
    send(0, 8'h12, 8'h34, 1'b0, 2);

    // Random traffic on the 8/4 and 8/8 instances.
    for (int i = 0; i < 20; i++)
      send(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 2);
    send(2, 8'hFF, 8'h01, 1'b0, 1);
    send(2, 8'h7F, 8'h7F, 1'b1, 1);
    for (int i = 0; i < 20; i++)
      send(2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1);

    // Exhaustive WIDTH=4, CHUNK=1.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          send(1, 8'(x), 8'(y), 1'(c), 4);

    repeat (3) @(negedge clk);
    check("drain_q8", exp_q0.size(), 0);
    check("drain_q4", exp_q1.size(), 0);
    check("drain_qw", exp_q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: a stuck handshake must not hang the run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
